// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - LIFO stack: top-of-stack register over a synchronous-read RAM
// Optional high-water output max_size enabled by LIFO_STACK_HIGH_WATER_EN.
module lifo_stack #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 replace,
    input  logic [WIDTH-1:0]     in_num,
    output logic [WIDTH-1:0]     top,
    output logic [ADDR_BITS:0]   size,
    output logic                 error,
`ifdef LIFO_STACK_HIGH_WATER_EN
    output logic [ADDR_BITS:0]   max_size,
`endif
    output logic                 out_vld
);

    localparam logic [ADDR_BITS:0] CAPACITY = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] ONE      = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic {READY, REFILL} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       top_q, top_d;
    logic [ADDR_BITS:0]     size_q, size_d;
    logic                   error_q, error_d;

    logic [WIDTH-1:0]       mem [0:(1<<ADDR_BITS)-1];
    logic [WIDTH-1:0]       rd_data_q;
    logic                   wr_en, rd_en;
    logic [ADDR_BITS:0]     size_m1, size_m2;
    logic [1:0]             cmd_cnt;
    logic                   any_cmd, illegal;

    always_comb begin
        cmd_cnt = 2'(push) + 2'(pop) + 2'(replace);
        any_cmd = push | pop | replace;
        illegal = any_cmd && ((cmd_cnt > 2'd1) || (state_q != READY)
                  || ((pop || replace) && (size_q == '0))
                  || (push && (size_q == CAPACITY)));
        size_m1 = size_q - ONE;
        size_m2 = size_q - (ONE << 1);

        state_d = state_q;
        top_d   = top_q;
        size_d  = size_q;
        error_d = error_q | illegal;
        wr_en   = 1'b0;
        rd_en   = 1'b0;

        case (state_q)
            READY: begin
                if (any_cmd && !illegal) begin
                    if (push) begin
                        wr_en  = (size_q != '0);
                        top_d  = in_num;
                        size_d = size_q + ONE;
                    end else if (replace) begin
                        top_d = in_num;
                    end else if (size_q == ONE) begin
                        top_d  = '0;
                        size_d = '0;
                    end else begin
                        // Next-deeper entry comes back from RAM one cycle later.
                        rd_en   = 1'b1;
                        size_d  = size_m1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                top_d   = rd_data_q;
                state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
            top_q   <= '0;
            size_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            size_q  <= size_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[size_m1[ADDR_BITS-1:0]] <= top_q;
        end
        if (rd_en) begin
            rd_data_q <= mem[size_m2[ADDR_BITS-1:0]];
        end
    end

`ifdef LIFO_STACK_HIGH_WATER_EN
    logic [ADDR_BITS:0] max_size_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            max_size_q <= '0;
        end else if (size_q > max_size_q) begin
            max_size_q <= size_q;
        end
    end

    assign max_size = max_size_q;
`endif

    assign top     = top_q;
    assign size    = size_q;
    assign error   = error_q;
    assign out_vld = (state_q == READY);

endmodule
